hex_display_driver: RTL and testbench
=====================================

# hex_display_driver

Parametrised multi-digit seven-segment driver for the DE1-SoC HEX displays. It accepts a binary value over a valid/ready handshake and renders it across DIGITS active-low segment groups, in hexadecimal or decimal. Decimal mode uses a sequential double-dabble BCD conversion. The block also provides leading-zero blanking, overflow dashes and a blink mode. It sits between game/score logic and the board HEX pins, and replaces per-digit combinational decoders.

## Interface
- DIGITS, 6: number of seven-segment digits driven (1..8).
- DATA_W, 20: width of the input value (4..32).
- BLINK_DIV, 25_000_000: clock cycles per blink half-period (≥2).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  value/mode inputs valid.
- in_ready  out  1  block idle and able to accept; high only in IDLE.
- value  in  DATA_W  binary number to display.
- decimal  in  1  1 = decimal rendering, 0 = hex; latched at accept.
- blank_lz  in  1  1 = blank leading zero digits; latched at accept.
- blink  in  1  1 = display flashes; live (not latched).
- busy  out  1  high in CONVERT and UPDATE.
- overflow  out  1  last accepted value not representable in DIGITS digits.
- hex  out  7*DIGITS  segments; digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}; 0 = lit.

## Operation
- Glyphs (7-bit, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E
  - dash=3F, blank=7F
- Accept: in_valid & in_ready at a rising edge. value, decimal and blank_lz are captured. Inputs are ignored while not in IDLE.
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE -> CONVERT on accept with decimal=1.
  - IDLE -> UPDATE on accept with decimal=0.
  - CONVERT runs exactly DATA_W shift steps, one per cycle, then goes to UPDATE.
  - UPDATE -> IDLE after one cycle.
- Hex mode:
  - Digit i = value[4i+3:4i]; bits beyond DATA_W read as zero.
  - overflow=1 if any value bit at position ≥ 4*DIGITS is set; the low 4*DIGITS bits are then shown as dashes.
- Decimal mode:
  - Double-dabble into a 4*DIGITS-bit BCD register: add 3 to every nibble ≥5, then shift left by one, MSB of value first.
  - overflow=1 if value > 10^DIGITS − 1 (comparison against a compile-time constant).
- Overflow display: every digit shows dash; blank_lz is ignored.
- Leading-zero blanking: when blank_lz=1, every digit above the most significant nonzero digit shows blank. Digit 0 is never blanked, so value 0 shows a single "0".
- UPDATE registers the final glyphs into the display register and updates overflow.
- Blink:
  - A free-running counter toggles a phase bit every BLINK_DIV cycles.
  - If blink=1 and phase=off, hex is forced to all-blank. The mask is combinational on the registered glyphs.
  - The counter runs regardless of FSM state.

## Timing
- Reset values:
  - hex all ones (all digits blank)
  - overflow 0, busy 0, in_ready 1
  - FSM IDLE, blink counter 0, phase on
- Hex-mode latency: accept at edge E0; hex and overflow update at E0+1; in_ready high again after E0+1.
- Decimal-mode latency: accept at E0; CONVERT covers edges E0+1..E0+DATA_W; hex updates at E0+DATA_W+1; in_ready is low for DATA_W+1 cycles.
- hex holds its previous contents until UPDATE; there are no intermediate glyphs.
- Back-to-back: a new accept is possible on the first edge at which in_ready=1 after UPDATE.
- Reset asserted mid-conversion: the FSM goes to IDLE immediately, the display blanks and the partial BCD is discarded.
- Blink phase change and UPDATE on the same edge: both take effect; the new glyphs are shown or masked according to the new phase.

## Test plan
Bench settings: DIGITS=6, DATA_W=20, BLINK_DIV=4.
- Reset pulse -> hex=42'h3FFFFFFFFFF, in_ready=1, busy=0, overflow=0.
- Hex mode, value=20'hABCDE, blank_lz=0 -> one edge after accept, digits 5..0 = 40,08,03,46,21,06; overflow=0.
- Decimal, value=20'd123456 -> in_ready low for 21 cycles, then digits 5..0 = 79,24,30,19,12,02; in_valid pulses during CONVERT are ignored.
- Decimal 20'd999999 -> all digits 10, overflow=0. Then 20'd1000000 -> all digits 3F, overflow=1.
- Decimal, blank_lz=1:
  - value 20'd42 -> digits 5..2 = 7F, digit1 = 19, digit0 = 24.
  - value 0 -> digits 5..1 = 7F, digit0 = 40.
- blink=1 with a steady display -> hex alternates shown/all-7F every 4 cycles.
- Reset asserted at cycle 10 of a CONVERT -> display blank, in_ready=1 on the next edge.

Source files
------------

// File: rtl/hex_display_driver.sv
// hex_display_driver: multi-digit seven-segment driver, hex or decimal.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready : accept handshake; value, decimal, blank_lz latched at accept
//   blink             : live flash enable
//   busy, overflow    : status
//   hex               : active-low segments, digit i at [7i+6:7i], {g,f,e,d,c,b,a}
module hex_display_driver #(
    parameter int DIGITS    = 6,
    parameter int DATA_W    = 20,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   value,
    input  logic                decimal,
    input  logic                blank_lz,
    input  logic                blink,
    output logic                busy,
    output logic                overflow,
    output logic [7*DIGITS-1:0] hex
);
    localparam int NB = 4 * DIGITS;
    localparam int SW = $clog2(DATA_W);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_UPDATE
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   val_q;
    logic [DATA_W-1:0]   sh_q;
    logic                dec_q;
    logic                blz_q;
    logic [NB-1:0]       bcd_q;
    logic [SW-1:0]       step_q;
    logic [7*DIGITS-1:0] hex_q;
    logic                ovf_q;
    logic                rdy_q;
    logic                busy_q;
    logic [CW-1:0]       bcnt_q;
    logic                off_q;

    logic [63:0]         val_ext;
    logic [NB-1:0]       adj_d;
    logic [NB-1:0]       bcd_d;
    logic [NB-1:0]       nib_d;
    logic                ovf_d;
    logic                lead_d;
    logic [7*DIGITS-1:0] glyph_d;

    assign val_ext = 64'(val_q);

    // Double-dabble step: correct every BCD nibble, then shift in next value MSB.
    always_comb begin
        adj_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                adj_d[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
        bcd_d = {adj_d[NB-2:0], sh_q[DATA_W-1]};
    end

    // Final glyphs; lead_d stays set while scanning zero digits from the top.
    always_comb begin
        nib_d   = dec_q ? bcd_q : val_ext[NB-1:0];
        ovf_d   = dec_q ? (val_ext > DEC_MAX) : ((val_ext >> NB) != 64'd0);
        glyph_d = '1;
        lead_d  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_d) begin
                glyph_d[7*i +: 7] = 7'h3F;
            end else if (blz_q && lead_d && (i != 0) && (nib_d[4*i +: 4] == 4'd0)) begin
                glyph_d[7*i +: 7] = 7'h7F;
            end else begin
                glyph_d[7*i +: 7] = seg7(nib_d[4*i +: 4]);
            end
            if (nib_d[4*i +: 4] != 4'd0) begin
                lead_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            sh_q    <= '0;
            dec_q   <= 1'b0;
            blz_q   <= 1'b0;
            bcd_q   <= '0;
            step_q  <= '0;
            hex_q   <= '1;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        val_q   <= value;
                        sh_q    <= value;
                        dec_q   <= decimal;
                        blz_q   <= blank_lz;
                        bcd_q   <= '0;
                        step_q  <= SW'(DATA_W - 1);
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= decimal ? S_CONVERT : S_UPDATE;
                    end
                end
                S_CONVERT: begin
                    bcd_q <= bcd_d;
                    sh_q  <= sh_q << 1;
                    if (step_q == '0) begin
                        state_q <= S_UPDATE;
                    end else begin
                        step_q <= step_q - SW'(1);
                    end
                end
                S_UPDATE: begin
                    hex_q   <= glyph_d;
                    ovf_q   <= ovf_d;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running blink phase, independent of the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q <= '0;
            off_q  <= 1'b0;
        end else if (bcnt_q == CNT_MAX) begin
            bcnt_q <= '0;
            off_q  <= ~off_q;
        end else begin
            bcnt_q <= bcnt_q + CW'(1);
        end
    end

    assign hex      = (blink && off_q) ? '1 : hex_q;
    assign in_ready = rdy_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// tb_hex_display_driver: directed stimulus with a cycle-level reference model.
// Model computes glyphs from arithmetic digit extraction and a latency countdown.
module tb_hex_display_driver;
    localparam int DIGITS    = 6;
    localparam int DATA_W    = 20;
    localparam int BLINK_DIV = 4;
    localparam logic [41:0] ALL_BLANK = 42'h3FFFFFFFFFF;
    localparam logic [6:0] GLY [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [19:0] value    = '0;
    logic        decimal  = 1'b0;
    logic        blank_lz = 1'b0;
    logic        blink    = 1'b0;
    logic        in_ready;
    logic        busy;
    logic        overflow;
    logic [41:0] hex;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hex_display_driver #(
        .DIGITS(DIGITS),
        .DATA_W(DATA_W),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .value(value),
        .decimal(decimal),
        .blank_lz(blank_lz),
        .blink(blink),
        .busy(busy),
        .overflow(overflow),
        .hex(hex)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Returns {overflow, hex} for a value rendered by the display rules.
    function automatic logic [42:0] render(input int v, input bit dec, input bit blz);
        int  base;
        int  p;
        int  msd;
        int  d [6];
        bit  ovf;
        logic [41:0] h;
        base = dec ? 10 : 16;
        ovf  = dec ? (v > 999999) : (v >= (1 << 24));
        msd  = 0;
        p    = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = (v / p) % base;
            if (d[i] != 0) msd = i;
            p = p * base;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf) h[7*i +: 7] = 7'h3F;
            else if (blz && i > msd) h[7*i +: 7] = 7'h7F;
            else h[7*i +: 7] = GLY[d[i]];
        end
        return {ovf, h};
    endfunction

    int          m_rem  = 0;
    int          m_cyc  = 0;
    logic [41:0] m_hex  = ALL_BLANK;
    logic        m_ovf  = 1'b0;
    logic [42:0] m_pend = '0;
    logic [41:0] exp_h;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem <= 0;
            m_cyc <= 0;
            m_hex <= ALL_BLANK;
            m_ovf <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_rem == 0) begin
                if (in_valid) begin
                    m_pend <= render(int'(value), decimal, blank_lz);
                    m_rem  <= decimal ? DATA_W + 1 : 1;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hex <= m_pend[41:0];
                    m_ovf <= m_pend[42];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            exp_h = (blink && ((m_cyc / BLINK_DIV) % 2 == 1)) ? ALL_BLANK : m_hex;
            check("model_hex", hex, exp_h);
            check("model_in_ready", in_ready, m_rem == 0);
            check("model_busy", busy, m_rem != 0);
            check("model_overflow", overflow, m_ovf);
        end
    end

    task automatic send(input logic [19:0] v, input logic dec, input logic blz);
        value    = v;
        decimal  = dec;
        blank_lz = blz;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int low);
        low = 0;
        @(negedge clk);
        while (!in_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
        check("ready_timeout", in_ready, 1);
    endtask

    int low;
    int nblank;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_hex", hex, ALL_BLANK);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);

        send(20'hABCDE, 1'b0, 1'b0);
        @(negedge clk);
        check("hex_hold", hex, ALL_BLANK);
        check("hex_busy", busy, 1);
        @(negedge clk);
        check("hex_ABCDE", hex, {7'h40, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06});
        check("hex_ovf", overflow, 0);
        check("hex_ready", in_ready, 1);

        send(20'd123456, 1'b1, 1'b0);
        low = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            in_valid = (k == 5);
            value    = 20'h00001;
            decimal  = 1'b0;
            if (in_ready) break;
            low++;
        end
        in_valid = 1'b0;
        check("dec_ready_low", low, 21);
        check("dec_123456", hex, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

        send(20'd999999, 1'b1, 1'b0);
        wait_idle(low);
        check("dec_999999", hex, {6{7'h10}});
        check("dec_999999_ovf", overflow, 0);

        send(20'd1000000, 1'b1, 1'b1);
        wait_idle(low);
        check("dec_1e6", hex, {6{7'h3F}});
        check("dec_1e6_ovf", overflow, 1);

        send(20'd42, 1'b1, 1'b1);
        wait_idle(low);
        check("blz_42", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
        check("blz_42_ovf", overflow, 0);

        send(20'd0, 1'b1, 1'b1);
        wait_idle(low);
        check("blz_0", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        send(20'h000F0, 1'b0, 1'b1);
        wait_idle(low);
        check("blz_hexF0", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40});
        check("blz_hexF0_low", low, 1);

        blink  = 1'b1;
        nblank = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (hex == ALL_BLANK) nblank++;
        end
        check("blink_blank_count", nblank, 8);
        blink = 1'b0;
        @(negedge clk);

        send(20'd123456, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_hex", hex, ALL_BLANK);
        check("midrst_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        send(20'd7, 1'b1, 1'b1);
        wait_idle(low);
        check("after_rst_7", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});
        check("after_rst_low", low, 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
